// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   ALU control code definitions shared between the ALU control decoder and
//   the execution unit, plus the flag bundle carried through the result stage.
//   Contents:
//     ALU_*              4-bit ALU control codes
//     alu_flags_t        {zero, overflow, illegal} flag bundle
//     alu_is_supported   1 when a control code names an implemented operation
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_BAD = 4'd15;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    function automatic logic alu_is_supported(input logic [3:0] code);
        logic ok;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: ok = 1'b1;
            default:                                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU: {code, a, b} -> {result, zero, overflow, illegal}.
//   Sits between the operand register and the result register of
//   alu_exec_unit.
//   Ports:
//     i_code      4      ALU control code
//     i_a, i_b    WIDTH  operands
//     o_result    WIDTH  operation result (0 for unsupported codes)
//     o_zero      1      o_result == 0
//     o_overflow  1      signed overflow, ADD/SUB only
//     o_illegal   1      code not in the supported set
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       i_code,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_illegal
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_lt;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;

    always_comb begin
        w_sum     = i_a + i_b;
        w_diff    = i_a - i_b;
        w_add_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
        w_sub_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
        // Signed less-than: sign of a-b, corrected when the subtraction overflowed.
        w_lt      = w_diff[MSB] ^ w_sub_ovf;
    end

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (i_code)
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_NOR: w_result = ~(i_a | i_b);
            ALU_ADD: begin
                w_result   = w_sum;
                w_overflow = w_add_ovf;
            end
            ALU_SUB: begin
                w_result   = w_diff;
                w_overflow = w_sub_ovf;
            end
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
            ALU_BAD: w_result = '0;
            default: w_result = '0;
        endcase
    end

    assign o_result   = w_result;
    assign o_zero     = (w_result == '0);
    assign o_overflow = w_overflow;
    assign o_illegal  = !alu_is_supported(i_code);

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Two-stage ALU execution unit with valid/ready handshakes on both sides.
//   S1 registers the accepted {code, a, b}; S2 registers the alu_core result
//   and all flags together. One operation per cycle, two edges of latency.
//   Ports:
//     clk        1      clock, rising edge
//     rst_n      1      asynchronous active-low reset
//     in_valid   1      operation presented
//     in_ready   1      operation accepted this cycle
//     alu_ctrl   4      ALU control code
//     op_a, op_b WIDTH  operands
//     out_valid  1      result presented
//     out_ready  1      consumer accepts result this cycle
//     result     WIDTH  operation result
//     zero       1      result == 0
//     overflow   1      signed overflow (ADD/SUB)
//     illegal    1      unsupported control code
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    // S1: operand register
    logic             r_in_en;
    logic             r_s1_valid;
    logic [3:0]       r_s1_code;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // S2: result register
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    logic             w_s2_load;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;

    // S2 takes a new result whenever it is empty or its current one leaves this edge,
    // so a draining output and a refill happen in the same edge without a bubble.
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    // r_in_en holds in_ready low until the first edge after reset release.
    assign in_ready  = r_in_en && (!r_s1_valid || w_s2_load);
    assign w_in_fire = in_valid && in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_code     (r_s1_code),
        .i_a        (r_s1_a),
        .i_b        (r_s1_b),
        .o_result   (w_result),
        .o_zero     (w_flags.zero),
        .o_overflow (w_flags.overflow),
        .o_illegal  (w_flags.illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_en    <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_in_en <= 1'b1;
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_code  <= alu_ctrl;
                r_s1_a     <= op_a;
                r_s1_b     <= op_b;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_result   <= w_result;
                r_flags    <= w_flags;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign zero      = r_flags.zero;
    assign overflow  = r_flags.overflow;
    assign illegal   = r_flags.illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        i;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic last_in_fire;
    int   acc;
    int   n_out;

    alu_exec_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // Reference model computed from the operation definitions with wide signed arithmetic.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint s;
        exp_t   e;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        e  = '0;
        case (c)
            4'd0:  e.r = a & b;
            4'd1:  e.r = a | b;
            4'd12: e.r = ~(a | b);
            4'd2: begin
                s   = sa + sb;
                e.r = s[31:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s   = sa - sb;
                e.r = s[31:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
    endtask

    // One clock: handshake bookkeeping at the negedge, then return 1 time unit after the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_in_fire = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_seq", 64'({result, zero, overflow, illegal}), 64'(e));
                n_out++;
            end
        end
        if (last_in_fire) exp_q.push_back(model(alu_ctrl, op_a, op_b));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
        return $urandom;
    endfunction

    function automatic logic [3:0] rand_code();
        logic [3:0] legal [6];
        legal[0] = 4'd0;
        legal[1] = 4'd1;
        legal[2] = 4'd2;
        legal[3] = 4'd6;
        legal[4] = 4'd7;
        legal[5] = 4'd12;
        if ($urandom_range(7) == 0) return 4'($urandom_range(15));
        return legal[$urandom_range(5)];
    endfunction

    exp_t       ops3 [4];
    logic [3:0] c3   [4];
    logic [31:0] a3  [4];
    logic [31:0] b3  [4];

    initial begin
        checks       = 0;
        failures     = 0;
        n_out        = 0;
        last_in_fire = 1'b0;
        rst_n        = 1'b0;
        out_ready    = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({result, zero, overflow, illegal}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // 1: ADD overflow, two-edge latency
        drive(1'b1, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("add_lat_edge1", 64'(out_valid), 64'd0);
        tick();
        chk("add_lat_edge2", 64'(out_valid), 64'd1);
        chk("add_ovf", 64'({result, zero, overflow, illegal}), 64'({32'h8000_0000, 1'b0, 1'b1, 1'b0}));
        tick();

        // 2: SUB then SLT back-to-back
        drive(1'b1, 4'd6, 32'd5, 32'd5);
        tick();
        drive(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("sub_zero", 64'({out_valid, result, zero, overflow, illegal}), 64'({1'b1, 32'd0, 1'b1, 1'b0, 1'b0}));
        tick();
        chk("slt_neg", 64'({out_valid, result, zero, overflow, illegal}), 64'({1'b1, 32'd1, 1'b0, 1'b0, 1'b0}));
        tick();

        // 3: stream four ops under backpressure
        c3[0] = 4'd0;  a3[0] = 32'hF0F0_1234; b3[0] = 32'h0FF0_FFFF;
        c3[1] = 4'd1;  a3[1] = 32'h1200_0034; b3[1] = 32'h0056_7800;
        c3[2] = 4'd12; a3[2] = 32'h0F0F_0000; b3[2] = 32'h0000_F0F0;
        c3[3] = 4'd2;  a3[3] = 32'h8000_0000; b3[3] = 32'h8000_0000;
        for (int i = 0; i < 4; i++) ops3[i] = model(c3[i], a3[i], b3[i]);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (acc < 4) drive(1'b1, c3[acc], a3[acc], b3[acc]);
            tick();
            if (last_in_fire) acc++;
        end
        chk("stall_accepted", 64'(acc), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_hold", 64'({out_valid, result, zero, overflow, illegal}), 64'({1'b1, ops3[0]}));
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (acc < 4) drive(1'b1, c3[acc], a3[acc], b3[acc]);
            else         drive(1'b0, 4'd0, 32'd0, 32'd0);
            tick();
            if (last_in_fire) acc++;
            if (acc == 4 && exp_q.size() == 0) break;
        end
        chk("stream_all_accepted", 64'(acc), 64'd4);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // 4: unsupported codes keep flowing
        drive(1'b1, 4'd15, 32'h0000_0123, 32'h0000_0456);
        tick();
        drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 4'd2, 32'd1, 32'd2);
        chk("illegal_15", 64'({out_valid, result, zero, overflow, illegal}), 64'({1'b1, 32'd0, 1'b1, 1'b0, 1'b1}));
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("illegal_3", 64'({out_valid, result, zero, overflow, illegal}), 64'({1'b1, 32'd0, 1'b1, 1'b0, 1'b1}));
        tick();
        chk("after_illegal", 64'({out_valid, result, zero, overflow, illegal}), 64'({1'b1, 32'd3, 1'b0, 1'b0, 1'b0}));
        tick();

        // 5: asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        tick();
        drive(1'b1, 4'd12, 32'd0, 32'd0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("full_before_rst", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_outputs", 64'({result, zero, overflow, illegal}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("no_stale_after_rst", 64'(out_valid), 64'd0);
        end

        // 6: random traffic against the reference model
        acc = 0;
        n_out = 0;
        for (int c = 0; c < 40000 && acc < 10000; c++) begin
            if ($urandom_range(3) != 0) drive(1'b1, rand_code(), rand_operand(), rand_operand());
            else                        drive(1'b0, rand_code(), rand_operand(), rand_operand());
            out_ready = ($urandom_range(3) != 0);
            tick();
            if (last_in_fire) acc++;
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        tick();
        chk("rand_accepted", 64'(acc), 64'd10000);
        chk("rand_outputs", 64'(n_out), 64'd10000);
        chk("rand_drained", 64'({exp_q.size(), out_valid}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
